// File: rtl/pack_pkg.sv
// pack_pkg: shared definitions for the 8-to-16 beat packer.
//   CNT_W        - width of the completed-word counter
//   pack_state_e - packing state (EMPTY: nothing held, HALF: first beat held)
package pack_pkg;

    localparam int CNT_W = 10;

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } pack_state_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a registered occupancy count.
//   clk, rst_n - clock, asynchronous active-low reset (clears storage too)
//   push, din  - write din when push is high and the FIFO is not full
//   pop        - drop the head when pop is high and the FIFO is not empty
//   flush      - empty the FIFO on this edge; overrides push/pop
//   dout       - current head entry, read straight from storage
//   full       - count equals DEPTH
//   empty      - count equals 0
//   count      - number of stored entries
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Storage is cleared on reset so the head reads as zero while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/pack_8to16.sv
// pack_8to16: packs pairs of IN_W-bit source beats into 2*IN_W-bit words
// and queues them in a small output FIFO.
//   clk, rst_n             - clock, asynchronous active-low reset
//   cfg_en                 - enable; while low, all buffered data is dropped
//   cfg_msb_first          - 0: first beat in low half, 1: first beat in high half
//   src_val/src_rdy/src_data - source beat handshake
//   dst_val/dst_rdy/dst_data - packed word handshake
//   sts_half               - a first beat is held waiting for its pair
//   sts_word_cnt           - completed destination handshakes, wraps at 1024
//
// state | meaning
// ------+----------------------------------------------
// EMPTY | no beat held; next accepted beat is a first beat
// HALF  | first beat in hold register; next beat completes a word
module pack_8to16
    import pack_pkg::*;
#(
    parameter int IN_W       = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_en,
    input  logic                cfg_msb_first,
    input  logic                src_val,
    output logic                src_rdy,
    input  logic [IN_W-1:0]     src_data,
    output logic                dst_val,
    input  logic                dst_rdy,
    output logic [2*IN_W-1:0]   dst_data,
    output logic                sts_half,
    output logic [CNT_W-1:0]    sts_word_cnt
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    pack_state_e       state;
    pack_state_e       state_nxt;
    logic [IN_W-1:0]   hold;
    logic [2*IN_W-1:0] word;
    logic              src_fire;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;

    // Ready depends only on registered occupancy, never on dst_rdy. rst_n is
    // folded in so ready reads low while reset is held with cfg_en high.
    assign src_rdy  = rst_n & cfg_en & (fifo_count < CW'(FIFO_DEPTH));
    assign src_fire = src_val & src_rdy;
    assign push     = src_fire & (state == HALF) & ~fifo_full;
    assign dst_val  = cfg_en & ~fifo_empty;
    assign pop      = dst_val & dst_rdy;

    assign word = cfg_msb_first ? {hold, src_data} : {src_data, hold};

    always_comb begin
        state_nxt = state;
        if (!cfg_en) begin
            state_nxt = EMPTY;
        end else if (src_fire) begin
            case (state)
                EMPTY:   state_nxt = HALF;
                HALF:    state_nxt = EMPTY;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            hold  <= '0;
        end else begin
            state <= state_nxt;
            if (!cfg_en) begin
                hold <= '0;
            end else if (src_fire && state == EMPTY) begin
                hold <= src_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sts_word_cnt <= '0;
        end else if (pop) begin
            sts_word_cnt <= sts_word_cnt + CNT_W'(1);
        end
    end

    // Gated with cfg_en so a held beat stops being reported as soon as
    // the block is disabled, not one edge later.
    assign sts_half = cfg_en & (state == HALF);

    sync_fifo #(
        .WIDTH (2*IN_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (~cfg_en),
        .din   (word),
        .dout  (dst_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_pack_8to16.sv
module tb_pack_8to16;

    localparam int IN_W  = 8;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_en;
    logic        cfg_msb_first;
    logic        src_val;
    logic        src_rdy;
    logic [7:0]  src_data;
    logic        dst_val;
    logic        dst_rdy;
    logic [15:0] dst_data;
    logic        sts_half;
    logic [9:0]  sts_word_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: words formed but not yet taken, plus any lone first beat.
    logic [15:0] exp_q[$];
    logic        have_first;
    logic [7:0]  first_b;
    int          exp_cnt;

    logic [15:0] got_q[$];

    always #5 clk = ~clk;

    pack_8to16 #(.IN_W(IN_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_en        (cfg_en),
        .cfg_msb_first (cfg_msb_first),
        .src_val       (src_val),
        .src_rdy       (src_rdy),
        .src_data      (src_data),
        .dst_val       (dst_val),
        .dst_rdy       (dst_rdy),
        .dst_data      (dst_data),
        .sts_half      (sts_half),
        .sts_word_cnt  (sts_word_cnt)
    );

    task automatic model_clear(input logic clr_cnt);
        exp_q.delete();
        have_first = 1'b0;
        first_b    = 8'h00;
        if (clr_cnt) exp_cnt = 0;
    endtask

    // One clock cycle: drive inputs just after a falling edge, compare the
    // DUT outputs with the model, then advance the model across the rising edge.
    task automatic step(input logic en, input logic msb, input logic sval,
                        input logic [7:0] d, input logic drdy,
                        output logic s_fire, output logic d_fire);
        logic [15:0] w;
        cfg_en = en; cfg_msb_first = msb; src_val = sval; src_data = d; dst_rdy = drdy;
        #1;
        checks++;
        if (src_rdy !== (en && exp_q.size() < DEPTH)) begin
            errors++;
            $display("FAIL step_src_rdy got %b exp %b", src_rdy, (en && exp_q.size() < DEPTH));
        end
        checks++;
        if (dst_val !== (en && exp_q.size() > 0)) begin
            errors++;
            $display("FAIL step_dst_val got %b exp %b", dst_val, (en && exp_q.size() > 0));
        end
        checks++;
        if (sts_half !== (en && have_first)) begin
            errors++;
            $display("FAIL step_sts_half got %b exp %b", sts_half, (en && have_first));
        end
        checks++;
        if (sts_word_cnt !== 10'(exp_cnt)) begin
            errors++;
            $display("FAIL step_word_cnt got %0d exp %0d", sts_word_cnt, exp_cnt);
        end
        if (en && exp_q.size() > 0) begin
            checks++;
            if (dst_data !== exp_q[0]) begin
                errors++;
                $display("FAIL step_dst_data got %h exp %h", dst_data, exp_q[0]);
            end
        end
        s_fire = sval & src_rdy;
        d_fire = dst_val & drdy;
        w      = dst_data;
        @(posedge clk);
        if (!en) begin
            model_clear(1'b0);
        end else begin
            if (d_fire) begin
                got_q.push_back(w);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                exp_cnt = (exp_cnt + 1) % 1024;
            end
            if (s_fire) begin
                if (have_first) begin
                    exp_q.push_back(msb ? {first_b, d} : {d, first_b});
                    have_first = 1'b0;
                end else begin
                    first_b    = d;
                    have_first = 1'b1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic send_beat(input logic msb, input logic [7:0] d, input logic drdy);
        logic sf, df;
        sf = 1'b0;
        for (int t = 0; t < 20 && !sf; t++) step(1'b1, msb, 1'b1, d, drdy, sf, df);
        if (!sf) begin
            errors++;
            $display("FAIL send_beat_timeout data %h not accepted", d);
        end
    endtask

    task automatic drain(input logic msb, input int cycles);
        logic sf, df;
        for (int t = 0; t < cycles; t++) step(1'b1, msb, 1'b0, 8'h00, 1'b1, sf, df);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; cfg_en = 1'b1; cfg_msb_first = 1'b0;
        src_val = 1'b1; src_data = 8'h5A; dst_rdy = 1'b1;
        model_clear(1'b1);
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({src_rdy, dst_val, sts_half} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b exp 000", {src_rdy, dst_val, sts_half});
        end
        checks++;
        if (dst_data !== 16'h0000) begin
            errors++;
            $display("FAIL reset_dst_data got %h exp 0000", dst_data);
        end
        checks++;
        if (sts_word_cnt !== 10'd0) begin
            errors++;
            $display("FAIL reset_word_cnt got %0d exp 0", sts_word_cnt);
        end
        src_val = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        got_q.delete();
        send_beat(1'b0, 8'h11, 1'b1);
        send_beat(1'b0, 8'h22, 1'b1);
        #1;
        checks++;
        if (dst_val !== 1'b1 || dst_data !== 16'h2211) begin
            errors++;
            $display("FAIL basic_latency got val %b data %h exp 1 2211", dst_val, dst_data);
        end
        drain(1'b0, 2);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== 16'h2211) begin
            errors++;
            $display("FAIL basic_word got %0d words first %h exp 1 word 2211",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 16'hxxxx);
        end
        checks++;
        if (sts_word_cnt !== 10'd1) begin
            errors++;
            $display("FAIL basic_word_cnt got %0d exp 1", sts_word_cnt);
        end
    endtask

    task automatic test_byte_order;
        got_q.delete();
        send_beat(1'b1, 8'h11, 1'b1);
        send_beat(1'b1, 8'h22, 1'b1);
        drain(1'b1, 2);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== 16'h1122) begin
            errors++;
            $display("FAIL byte_order got %0d words first %h exp 1 word 1122",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 16'hxxxx);
        end
    endtask

    task automatic test_backpressure;
        logic sf, df;
        int   idx;
        logic [15:0] exp_w [3];
        exp_w[0] = 16'h0201; exp_w[1] = 16'h0403; exp_w[2] = 16'h0605;
        got_q.delete();
        idx = 1;
        for (int t = 0; t < 10; t++) begin
            step(1'b1, 1'b0, 1'b1, 8'(idx), 1'b0, sf, df);
            if (sf) idx++;
        end
        checks++;
        if (idx - 1 != 4) begin
            errors++;
            $display("FAIL bp_accepted got %0d beats exp 4", idx - 1);
        end
        #1;
        checks++;
        if (src_rdy !== 1'b0) begin
            errors++;
            $display("FAIL bp_src_rdy_low got %b exp 0", src_rdy);
        end
        for (int t = 0; t < 30 && got_q.size() < 3; t++) begin
            step(1'b1, 1'b0, (idx <= 6), 8'(idx), 1'b1, sf, df);
            if (sf) idx++;
        end
        checks++;
        if (got_q.size() != 3) begin
            errors++;
            $display("FAIL bp_word_count got %0d exp 3", got_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            if (i < got_q.size()) begin
                checks++;
                if (got_q[i] !== exp_w[i]) begin
                    errors++;
                    $display("FAIL bp_order[%0d] got %h exp %h", i, got_q[i], exp_w[i]);
                end
            end
        end
    endtask

    task automatic test_disable_mid_word;
        logic sf, df;
        got_q.delete();
        send_beat(1'b0, 8'hAA, 1'b1);
        step(1'b0, 1'b0, 1'b1, 8'h77, 1'b1, sf, df);
        checks++;
        if (sf) begin
            errors++;
            $display("FAIL dis_accept got beat accepted while disabled exp none");
        end
        send_beat(1'b0, 8'hBB, 1'b1);
        send_beat(1'b0, 8'hCC, 1'b1);
        drain(1'b0, 3);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== 16'hCCBB) begin
            errors++;
            $display("FAIL dis_word got %0d words first %h exp 1 word ccbb",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 16'hxxxx);
        end
    endtask

    task automatic test_random;
        logic sf, df;
        int   words;
        got_q.delete();
        for (int t = 0; t < 600; t++) begin
            step(($urandom_range(0, 19) != 0), 1'($urandom), 1'($urandom),
                 8'($urandom), ($urandom_range(0, 3) != 0), sf, df);
        end
        drain(1'b0, 4);
        words = got_q.size();
        checks++;
        if (words < 20) begin
            errors++;
            $display("FAIL random_traffic got %0d words exp at least 20", words);
        end
    endtask

    task automatic test_wrap;
        logic sf, df;
        int   t;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear(1'b1);
        got_q.delete();
        t = 0;
        while (got_q.size() < 1025 && t < 5000) begin
            step(1'b1, 1'b0, 1'b1, 8'($urandom), 1'b1, sf, df);
            // Stop sourcing once the last needed word is formed.
            if ((got_q.size() + exp_q.size()) >= 1025 && !have_first) begin
                drain(1'b0, 3);
            end
            t++;
        end
        checks++;
        if (got_q.size() != 1025) begin
            errors++;
            $display("FAIL wrap_words got %0d exp 1025", got_q.size());
        end
        checks++;
        if (sts_word_cnt !== 10'd1) begin
            errors++;
            $display("FAIL wrap_word_cnt got %0d exp 1", sts_word_cnt);
        end
    endtask

    task automatic test_reset_mid;
        got_q.delete();
        send_beat(1'b0, 8'h33, 1'b0);
        send_beat(1'b0, 8'h44, 1'b0);
        send_beat(1'b0, 8'h55, 1'b0);
        #1;
        checks++;
        if (sts_half !== 1'b1) begin
            errors++;
            $display("FAIL rmid_half_before got %b exp 1", sts_half);
        end
        cfg_en = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({src_rdy, dst_val, sts_half} !== 3'b000 || dst_data !== 16'h0000) begin
            errors++;
            $display("FAIL rmid_outputs got flags %b data %h exp 000 0000",
                     {src_rdy, dst_val, sts_half}, dst_data);
        end
        checks++;
        if (sts_word_cnt !== 10'd0) begin
            errors++;
            $display("FAIL rmid_word_cnt got %0d exp 0", sts_word_cnt);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear(1'b1);
        send_beat(1'b0, 8'h5A, 1'b1);
        send_beat(1'b0, 8'hA5, 1'b1);
        drain(1'b0, 2);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== 16'hA55A) begin
            errors++;
            $display("FAIL rmid_fresh_word got %0d words first %h exp 1 word a55a",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 16'hxxxx);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_byte_order();
        test_backpressure();
        test_disable_mid_word();
        test_random();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pack_8to16.md
PACK_8TO16 -- requirements
Module: pack_8to16

Interface
REQ-001 The block SHALL have parameter IN_W, default 8, giving the source beat width in bits.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 2, giving the output FIFO depth in words (power of two, at least 2).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active low.
REQ-006 cfg_en  input  1  enable, active high; protocol may be violated on disable.
REQ-007 cfg_msb_first  input  1  byte order: 0 puts the first beat in the low half, 1 puts it in the high half.
REQ-008 src_val  input  1  source valid, active high.
REQ-009 src_rdy  output  1  source ready, active high.
REQ-010 src_data  input  IN_W  source data; stable while src_val is high.
REQ-011 dst_val  output  1  destination valid, active high.
REQ-012 dst_rdy  input  1  destination ready, active high.
REQ-013 dst_data  output  2*IN_W  packed word; stable while dst_val is high.
REQ-014 sts_half  output  1  high while one source beat is held waiting for its pair.
REQ-015 sts_word_cnt  output  10  count of completed dst handshakes; wraps from 1023 to 0.

Function
REQ-016 A source beat SHALL transfer on a rising edge where src_val and src_rdy are both high; a destination word SHALL transfer on a rising edge where dst_val and dst_rdy are both high.
REQ-017 Packing SHALL use a two-state machine, EMPTY and HALF. EMPTY goes to HALF on a source beat, which is captured into the hold register. HALF goes to EMPTY on a source beat, which forms a word and pushes it into the FIFO.
REQ-018 The formed word SHALL be {second, first} when cfg_msb_first = 0 and {first, second} when cfg_msb_first = 1. cfg_msb_first is sampled on the edge of the second beat.
REQ-019 src_rdy SHALL be high when cfg_en = 1 and the registered FIFO count is below FIFO_DEPTH. There SHALL be no combinational path from dst_rdy to src_rdy.
REQ-020 dst_val SHALL equal cfg_en AND (FIFO not empty). dst_data SHALL be the FIFO head, driven from a register or from RAM, with no combinational path from src_* to dst_*.
REQ-021 Latency: a word whose second beat is accepted at edge N SHALL show dst_val = 1 immediately after edge N.
REQ-022 A push and a pop on the same edge SHALL leave the FIFO count unchanged; on a full FIFO, src_rdy stays low for that cycle.
REQ-023 Words SHALL leave in the order they were formed, with no loss or duplication, while cfg_en stays 1.
REQ-024 sts_word_cnt SHALL increment by 1 on each dst handshake and wrap modulo 1024.
REQ-025 While cfg_en = 0, the block SHALL hold src_rdy = 0 and dst_val = 0. On each such edge it SHALL flush the FIFO, return the FSM to EMPTY and discard any held beat. sts_word_cnt SHALL be retained.
REQ-026 cfg_en falling mid-word SHALL discard the partial beat. After cfg_en rises again, the next accepted beat SHALL be treated as a first beat.

Reset
REQ-027 On rst_n = 0, the block SHALL asynchronously set: FSM = EMPTY, FIFO empty, hold register = 0, sts_word_cnt = 0.
REQ-028 During reset the outputs SHALL be src_rdy = 0, dst_val = 0, dst_data = 0, sts_half = 0, sts_word_cnt = 0.
REQ-029 Reset asserted mid-transfer SHALL discard all buffered data. The first accepted beat after release SHALL be a first beat.

Structure
REQ-030 Package pack_pkg SHALL hold the FSM state enum (EMPTY, HALF) and the localparam CNT_W = 10.
REQ-031 Output buffering SHALL be a sub-module sync_fifo (parameters WIDTH and DEPTH; ports push, pop, flush, full, empty, count), instantiated once.

Verification
REQ-032 Basic packing: cfg_en = 1, cfg_msb_first = 0, beats 0x11 then 0x22, dst_rdy = 1 -> one word 0x2211, dst_val high the cycle after the second beat, sts_word_cnt = 1.
REQ-033 Byte order: same beats with cfg_msb_first = 1 -> word 0x1122.
REQ-034 Backpressure: dst_rdy = 0, stream beats 0x01..0x06 -> src_rdy falls after 4 beats (2 words queued). Raising dst_rdy then yields 0x0201, 0x0403, 0x0605 in order.
REQ-035 Disable mid-word: send beat 0xAA, drop cfg_en for 1 cycle, send 0xBB and 0xCC -> only word 0xCCBB, and sts_half = 0 during disable.
REQ-036 Wrap and reset: 1025 words -> sts_word_cnt = 1. Assert rst_n = 0 asynchronously with sts_half = 1 -> all outputs 0 immediately, next beat pair forms a fresh word.
